// File: rtl/pulse_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_receiver: synchronises the active-low _pulse line and measures each |
// | low period, flagging accepted pulses, glitches and a stuck-low line.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pulse_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH_BITS  = 8,
  parameter int MIN_WIDTH   = 2,
  parameter int MAX_WIDTH   = 200,
  parameter int COUNT_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  _pulse,
  input  logic                  en,
  output logic                  valid,
  output logic [WIDTH_BITS-1:0] width,
  output logic                  glitch,
  output logic                  stuck,
  output logic [COUNT_BITS-1:0] pulse_count,
  output logic [COUNT_BITS-1:0] glitch_count
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    LOW       = 2'd2,
    STUCK     = 2'd3
  } state_t;

  localparam logic [WIDTH_BITS-1:0] c_cnt_one = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_BITS-1:0] c_min     = WIDTH_BITS'(MIN_WIDTH);
  localparam logic [WIDTH_BITS-1:0] c_max     = WIDTH_BITS'(MAX_WIDTH);
  localparam logic [COUNT_BITS-1:0] c_ctr_one = {{(COUNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNT_BITS-1:0] c_ctr_max = {COUNT_BITS{1'b1}};

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [SYNC_STAGES-1:0]  r_settle;
  logic [WIDTH_BITS-1:0]   r_cnt;
  logic                    w_s;
  logic                    w_settled;
  logic [WIDTH_BITS-1:0]   w_cnt_next;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_cnt_next = r_cnt + c_cnt_one;
  // The synchroniser resets to "high"; trust it only once real pin samples have reached its output,
  // otherwise a line held low through reset would be seen as a fresh falling edge.
  assign w_settled  = &r_settle;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_sync       <= '1;
      r_settle     <= '0;
      r_state      <= WAIT_HIGH;
      r_cnt        <= '0;
      valid        <= 1'b0;
      width        <= '0;
      glitch       <= 1'b0;
      stuck        <= 1'b0;
      pulse_count  <= '0;
      glitch_count <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], _pulse};
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      valid    <= 1'b0;
      glitch   <= 1'b0;
      case (r_state)
        WAIT_HIGH: begin
          if (w_settled && w_s) r_state <= IDLE;
        end
        IDLE: begin
          if (en && !w_s) begin
            r_state <= LOW;
            r_cnt   <= c_cnt_one;
          end
        end
        LOW: begin
          if (!en) begin
            r_state <= WAIT_HIGH;
          end else if (!w_s) begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == c_max) begin
              r_state <= STUCK;
              stuck   <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
            if (r_cnt < c_min) begin
              glitch <= 1'b1;
              if (glitch_count != c_ctr_max) glitch_count <= glitch_count + c_ctr_one;
            end else begin
              valid       <= 1'b1;
              width       <= r_cnt;
              pulse_count <= pulse_count + c_ctr_one;
            end
          end
        end
        STUCK: begin
          if (w_s) begin
            r_state <= IDLE;
            stuck   <= 1'b0;
          end
        end
        default: r_state <= WAIT_HIGH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pulse_receiver: directed pulse stimulus against an event-schedule model |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pulse_receiver;

  localparam int SYNC = 2;
  localparam int MINW = 2;
  localparam int MAXW = 200;

  logic       clk    = 1'b0;
  logic       _reset = 1'b0;
  logic       _pulse = 1'b0;
  logic       en     = 1'b1;
  logic       valid;
  logic [7:0] width;
  logic       glitch;
  logic       stuck;
  logic [7:0] pulse_count;
  logic [7:0] glitch_count;

  pulse_receiver dut (
    .clk          (clk),
    ._reset       (_reset),
    ._pulse       (_pulse),
    .en           (en),
    .valid        (valid),
    .width        (width),
    .glitch       (glitch),
    .stuck        (stuck),
    .pulse_count  (pulse_count),
    .glitch_count (glitch_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err    = 0;
  int n_checks = 0;
  int n_valid  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each pulse the bench drives becomes a scheduled outcome computed from its length.
  typedef struct {
    int cyc;
    bit is_glitch;
    int w;
  } ev_t;
  ev_t evq[$];
  int  m_pcnt = 0, m_gcnt = 0, m_width = 0;
  int  stuck_from = -1, stuck_to = -2;

  // A pin low for n edges after edge p is seen low by the synchroniser output on edges
  // p+SYNC+1 .. p+SYNC+n; the outcome lands on the following edge.
  task automatic schedule(input int p, input int n);
    ev_t e;
    if (n < MINW) begin
      e.cyc = p + n + SYNC + 1; e.is_glitch = 1'b1; e.w = 0; evq.push_back(e);
    end else if (n < MAXW) begin
      e.cyc = p + n + SYNC + 1; e.is_glitch = 1'b0; e.w = n; evq.push_back(e);
    end else begin
      stuck_from = p + SYNC + MAXW;
      stuck_to   = p + SYNC + n;
    end
  endtask

  always @(negedge clk) begin
    logic e_valid, e_glitch, e_stuck;
    e_valid  = 1'b0;
    e_glitch = 1'b0;
    if (!_reset) begin
      evq.delete();
      m_pcnt = 0; m_gcnt = 0; m_width = 0;
      stuck_from = -1; stuck_to = -2;
    end else begin
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev_t e;
        e = evq.pop_front();
        if (e.is_glitch) begin
          e_glitch = 1'b1;
          m_gcnt   = (m_gcnt < 255) ? m_gcnt + 1 : 255;
        end else begin
          e_valid = 1'b1;
          m_pcnt  = (m_pcnt + 1) % 256;
          m_width = e.w;
        end
      end
    end
    e_stuck = (cyc >= stuck_from) && (cyc <= stuck_to);
    chk("valid", valid, e_valid);
    chk("glitch", glitch, e_glitch);
    chk("stuck", stuck, e_stuck);
    chk("width", width, m_width);
    chk("pulse_count", pulse_count, m_pcnt);
    chk("glitch_count", glitch_count, m_gcnt);
    if (valid) n_valid++;
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one low period of n cycles followed by gap high cycles; scheduled only if enabled.
  task automatic pulse(input int n, input int gap);
    int p;
    @(posedge clk);
    #1;
    p = cyc;
    _pulse = 1'b0;
    if (en) schedule(p, n);
    tick(n);
    _pulse = 1'b1;
    tick(gap - 1);
  endtask

  initial begin
    int base;
    // T1: reset with the line low, then a low period right after release
    tick(3);
    chk("t1_rst_valid", valid, 0);
    chk("t1_rst_stuck", stuck, 0);
    chk("t1_rst_pcount", pulse_count, 0);
    _reset = 1'b1;
    tick(10);
    _pulse = 1'b1;
    tick(6);
    chk("t1_pcount", pulse_count, 0);
    chk("t1_nvalid", n_valid, 0);

    // T2: nominal 5-cycle pulse
    pulse(5, 6);
    chk("t2_width", width, 5);
    chk("t2_pcount", pulse_count, 1);
    chk("t2_gcount", glitch_count, 0);

    // T3: glitch, then a pulse exactly at the minimum width
    pulse(1, 6);
    chk("t3_gcount", glitch_count, 1);
    chk("t3_width_held", width, 5);
    pulse(2, 6);
    chk("t3_min_width", width, 2);

    // T4: stuck line, exact stuck threshold, and longest accepted pulse
    pulse(250, 6);
    chk("t4_stuck_clr", stuck, 0);
    chk("t4_pcount", pulse_count, 2);
    chk("t4_gcount", glitch_count, 1);
    pulse(200, 6);
    pulse(199, 6);
    chk("t4_max_width", width, 199);

    // T5: disabled pulse ignored; enable dropped mid-pulse discards it
    en = 1'b0;
    tick(2);
    base = n_valid;
    pulse(5, 6);
    chk("t5_dis_nvalid", n_valid, base);
    en = 1'b1;
    tick(2);
    @(posedge clk);
    #1;
    _pulse = 1'b0;
    tick(4);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(3);
    _pulse = 1'b1;
    tick(6);
    chk("t5_abort_pcount", pulse_count, 3);
    pulse(3, 6);
    chk("t5_width", width, 3);
    chk("t5_pcount", pulse_count, 4);

    // T6: fresh reset, counter wrap and glitch saturation with 1-cycle high gaps
    _reset = 1'b0;
    tick(2);
    chk("t6_rst_pcount", pulse_count, 0);
    chk("t6_rst_width", width, 0);
    _reset = 1'b1;
    tick(4);
    base = n_valid;
    for (int i = 0; i < 257; i++) pulse(3, (i == 256) ? 6 : 1);
    chk("t6_nvalid", n_valid - base, 257);
    chk("t6_pcount_wrap", pulse_count, 1);
    for (int i = 0; i < 300; i++) pulse(1, (i == 299) ? 6 : 1);
    chk("t6_gcount_sat", glitch_count, 255);
    chk("t6_pcount_after", pulse_count, 1);
    chk("t6_width_after", width, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
